// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants, index type and pad-width helper
package i2s_pkg;

   localparam int FRAME_BITS = 64;
   localparam int SLOT_W_DEF = 32;
   localparam int DATA_W_DEF = 16;

   typedef logic [5:0] frame_idx_t;

   function automatic int pad_width(input int data_w, input int slot_w);
      return slot_w - data_w;
   endfunction

   localparam int PAD_W_DEF = pad_width(DATA_W_DEF, SLOT_W_DEF);

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit clock divider with same-edge fall/rise strobes
module i2s_bclk_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic bclk,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             wrap;

   assign wrap = (div_cnt == DIV_W'(CLK_DIV - 1));

   // Strobes mark the clk edge on which bclk toggles, so users update in lockstep with it.
   assign fall_stb = wrap & bclk;
   assign rise_stb = wrap & ~bclk;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter with 1-entry holding register
// Optional I2S_TX_REPEAT_EN: on underrun resend the last transmitted pair instead of zeros.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SLOT_W  = SLOT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_ldata,
   input  logic [DATA_W-1:0] in_rdata,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              audio_bclk,
   output logic              audio_lrclk,
   output logic              audio_sdata,
   output logic              underrun
);

   localparam int         PAD_W      = pad_width(DATA_W, SLOT_W);
   localparam int         FRAME_W    = 2 * SLOT_W;
   localparam frame_idx_t FRAME_LAST = frame_idx_t'(FRAME_BITS - 1);
   localparam frame_idx_t HALF_FRAME = frame_idx_t'(FRAME_BITS / 2);

   function automatic logic [SLOT_W-1:0] slot_of(input logic [DATA_W-1:0] d);
      return SLOT_W'(d) << PAD_W;
   endfunction

   logic               fall_stb;
   logic               unused_rise_stb;
   frame_idx_t         k;
   frame_idx_t         k_next;
   logic [FRAME_W-1:0] shift;
   logic               hold_full;
   logic [DATA_W-1:0]  hold_l;
   logic [DATA_W-1:0]  hold_r;
   logic               accept;
   logic               load;
`ifdef I2S_TX_REPEAT_EN
   logic [DATA_W-1:0]  last_l;
   logic [DATA_W-1:0]  last_r;
`endif

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bclk_gen (
      .clk      (clk),
      .rst      (rst),
      .bclk     (audio_bclk),
      .fall_stb (fall_stb),
      .rise_stb (unused_rise_stb)
   );

   assign k_next = k + frame_idx_t'(1);
   assign accept = in_valid && in_ready;
   assign load   = fall_stb && (k == FRAME_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         k           <= FRAME_LAST;
         shift       <= '0;
         hold_full   <= 1'b0;
         hold_l      <= '0;
         hold_r      <= '0;
         in_ready    <= 1'b0;
         audio_lrclk <= 1'b0;
         audio_sdata <= 1'b0;
         underrun    <= 1'b0;
`ifdef I2S_TX_REPEAT_EN
         last_l      <= '0;
         last_r      <= '0;
`endif
      end else begin
         underrun <= 1'b0;

         // A pair accepted on a load edge was not visible to that load; it waits a frame.
         if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= in_ldata;
            hold_r    <= in_rdata;
            in_ready  <= 1'b0;
         end else if (load && hold_full) begin
            hold_full <= 1'b0;
            in_ready  <= 1'b1;
         end else begin
            in_ready  <= !hold_full;
         end

         if (fall_stb) begin
            k           <= k_next;
            audio_lrclk <= (k_next >= HALF_FRAME);
            // MSB-first with one bit of delay: the old frame's last bit goes out as the new one loads.
            audio_sdata <= shift[FRAME_W-1];
            if (load) begin
               if (hold_full) begin
                  shift  <= {slot_of(hold_l), slot_of(hold_r)};
`ifdef I2S_TX_REPEAT_EN
                  last_l <= hold_l;
                  last_r <= hold_r;
`endif
               end else begin
                  underrun <= 1'b1;
`ifdef I2S_TX_REPEAT_EN
                  shift    <= {slot_of(last_l), slot_of(last_r)};
`else
                  shift    <= '0;
`endif
               end
            end else begin
               shift <= shift << 1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed/randomized bench for i2s_tx with an I2S sink model and frame scoreboard
module tb_i2s_tx;

   localparam int CLK_DIV = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_ldata = '0;
   logic [15:0] in_rdata = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        audio_bclk;
   logic        audio_lrclk;
   logic        audio_sdata;
   logic        underrun;

   int tests = 0;
   int fails = 0;

   i2s_tx #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (16),
      .SLOT_W  (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_ldata    (in_ldata),
      .in_rdata    (in_rdata),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .audio_bclk  (audio_bclk),
      .audio_lrclk (audio_lrclk),
      .audio_sdata (audio_sdata),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // Sink model: decodes words by lrclk transitions seen on bclk rises.
   logic [63:0] rx_q[$];
   bit          fs_q[$];
   logic [31:0] sr, left_w;
   bit          have_left, have_rise, have_change;
   logic        pb, plr, psd, pur, lr_at_rise;
   int          clks_since_rise, rises_cnt;
   int          ur_cnt = 0, frames_seen = 0, ones_cnt = 0;
   int          pulse_bad = 0, edge_bad = 0, period_bad = 0, lr_run_bad = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            rx_q.delete(); fs_q.delete();
            sr = '0; left_w = '0; have_left = 0; have_rise = 0; have_change = 0;
            pb = 0; plr = 0; psd = 0; pur = 0; lr_at_rise = 0;
            clks_since_rise = 0; rises_cnt = 0; frames_seen = 0;
         end else begin
            if (underrun && pur) pulse_bad++;
            if (underrun) begin
               ur_cnt++;
               fs_q.push_back(1'b1);
            end else if (plr && !audio_lrclk) begin
               fs_q.push_back(1'b0);
            end
            if ((audio_lrclk !== plr || audio_sdata !== psd) && !(pb && !audio_bclk)) edge_bad++;
            if (audio_sdata) ones_cnt++;
            if (!pb && audio_bclk) begin
               if (have_rise && clks_since_rise != 2 * CLK_DIV) period_bad++;
               clks_since_rise = 0;
               have_rise = 1;
               sr = {sr[30:0], audio_sdata};
               if (audio_lrclk != lr_at_rise) begin
                  if (!lr_at_rise) begin
                     left_w = sr;
                     have_left = 1;
                  end else if (have_left) begin
                     rx_q.push_back({left_w, sr});
                     have_left = 0;
                     frames_seen++;
                  end
                  if (have_change && rises_cnt != 32) lr_run_bad++;
                  have_change = 1;
                  rises_cnt = 1;
               end else begin
                  rises_cnt++;
               end
               lr_at_rise = audio_lrclk;
            end
            clks_since_rise++;
            pb = audio_bclk; plr = audio_lrclk; psd = audio_sdata; pur = underrun;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [63:0] exp_q[$];
   logic [63:0] last_tx = '0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
      return {l, 16'h0000, r, 16'h0000};
   endfunction

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      int b = 0;
      in_ldata = l; in_rdata = r; in_valid = 1'b1;
      while (!in_ready && b < 600) begin tick(1); b++; end
      check("push_ready", in_ready, 1'b1);
      tick(1);
      in_valid = 1'b0;
      exp_q.push_back(frame_of(l, r));
   endtask

   task automatic wait_frames(input int n);
      int target = frames_seen + n;
      int b = 0;
      while (frames_seen < target && b < n * 300 + 600) begin tick(1); b++; end
      check("wait_frames", frames_seen >= target, 1'b1);
   endtask

   // Each decoded frame is either the next pushed pair or, when it began with underrun, the fill frame.
   task automatic score();
      logic [63:0] got, exp;
      bit          ur;
      while (rx_q.size() > 0) begin
         got = rx_q.pop_front();
         check("frame_start_seen", fs_q.size() > 0, 1'b1);
         ur = (fs_q.size() > 0) ? fs_q.pop_front() : 1'b1;
         if (ur) begin
`ifdef I2S_TX_REPEAT_EN
            exp = last_tx;
`else
            exp = '0;
`endif
         end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            last_tx = exp;
         end else begin
            exp = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         check("frame", got, exp);
      end
   endtask

   initial begin
      logic [15:0] base, l, r;
      int ur0, b, falls, first_ur;
      logic prev_lr, prev_b;

      // Reset state
      tick(2);
      check("reset_outputs", {audio_bclk, audio_lrclk, audio_sdata, underrun, in_ready}, 5'b0);
      rst = 1'b0;
      tick(1);
      check("ready_after_reset", in_ready, 1'b1);

      // Idle: zero frames, one underrun per frame
      tick(20);
      ur0 = ur_cnt;
      tick(512);
      check("idle_underruns", ur_cnt - ur0, 2);
      check("idle_sdata_zero", ones_cnt, 0);
      score();

      // Single known pair
      push(16'hA5C3, 16'h0F01);
      wait_frames(2);
      score();

      // Back-to-back stream L=n, R=~n
      base = 16'($urandom_range(0, 16'hFFF0));
      push(base, ~base);
      push(base + 16'd1, ~(base + 16'd1));
      ur0 = ur_cnt;
      for (int i = 2; i < 8; i++) push(base + 16'(i), ~(base + 16'(i)));
      b = 0;
      while (!in_ready && b < 600) begin tick(1); b++; end
      check("stream_no_underrun", ur_cnt - ur0, 0);
      wait_frames(1);
      score();

      // Backpressure with in_valid held high
      l = 16'($urandom); r = 16'($urandom) | 16'h1;
      in_ldata = l; in_rdata = r; in_valid = 1'b1;
      check("bp_ready_idle", in_ready, 1'b1);
      tick(1);
      exp_q.push_back(frame_of(l, r));
      l = 16'($urandom); r = 16'($urandom) | 16'h2;
      in_ldata = l; in_rdata = r;
      check("bp_ready_low", in_ready, 1'b0);
      prev_lr = audio_lrclk;
      b = 0;
      while (!in_ready && b < 600) begin prev_lr = audio_lrclk; tick(1); b++; end
      check("bp_release_at_load", {prev_lr, audio_lrclk}, 2'b10);
      tick(1);
      check("bp_second_taken", in_ready, 1'b0);
      in_valid = 1'b0;
      exp_q.push_back(frame_of(l, r));
      b = 0;
      while (!in_ready && b < 600) begin tick(1); b++; end
      wait_frames(1);
      score();

      // Underrun then arrival
      ur0 = ur_cnt;
      b = 0;
      while (ur_cnt == ur0 && b < 600) begin tick(1); b++; end
      push(16'($urandom) | 16'h8000, 16'($urandom));
      check("ur_single", ur_cnt - ur0, 1);
      wait_frames(2);
      score();

      // Reset at k=40 with a pair waiting in the holding register
      push(16'($urandom) | 16'h4000, 16'($urandom));
      b = 0;
      while (audio_lrclk !== 1'b1 && b < 600) begin tick(1); b++; end
      prev_b = audio_bclk;
      falls = 0;
      while (falls < 8 && b < 1200) begin
         tick(1); b++;
         if (prev_b && !audio_bclk) falls++;
         prev_b = audio_bclk;
      end
      check("k40_lrclk", audio_lrclk, 1'b1);
      rst = 1'b1;
      tick(1);
      check("midframe_reset_outputs", {audio_bclk, audio_lrclk, audio_sdata, underrun, in_ready}, 5'b0);
      rst = 1'b0;
      exp_q.delete();
      last_tx = '0;
      first_ur = 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         if (i == 1) check("ready_after_midreset", in_ready, 1'b1);
         if (underrun && first_ur == 0) begin
            first_ur = i;
            check("first_frame_lrclk", audio_lrclk, 1'b0);
         end
      end
      check("first_frame_edge", first_ur, 2 * CLK_DIV);
      push(16'($urandom) | 16'h0100, 16'($urandom));
      wait_frames(2);
      score();

      // Protocol invariants over the whole run
      check("underrun_width", pulse_bad, 0);
      check("lr_sd_on_fall_only", edge_bad, 0);
      check("bclk_period", period_bad, 0);
      check("lrclk_32_bclk", lr_run_bad, 0);
      check("all_expected_sent", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter, the send-side counterpart of the team's I2S receiver.
- Takes parallel 16-bit left/right sample pairs over a valid/ready handshake and serializes them MSB-first in 32-bit slots.
- Generates audio_bclk and audio_lrclk from the system clock.
- Sits between the audio sample source (DSP/FIFO) and the codec or S/PDIF bridge; output loops back directly into the I2S receiver for test.

Parameters:
- CLK_DIV, 4, system clocks per bclk half-period (>=1); Fs = f_clk / (2*CLK_DIV*64)
- DATA_W, 16, sample width per channel
- SLOT_W, 32, bits per channel slot; DATA_W MSBs carry data, remainder zero-padded

Ports:
- clk  in  1  system clock; sole clock; every output is a register in this domain
- rst  in  1  reset, synchronous, active-high
- in_ldata  in  DATA_W  left sample
- in_rdata  in  DATA_W  right sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding register empty; transfer on in_valid & in_ready at rising clk
- audio_bclk  out  1  bit clock
- audio_lrclk  out  1  word select; 0 = left, 1 = right
- audio_sdata  out  1  serial data
- underrun  out  1  one-clk pulse when a frame starts with no sample available

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1. On wrap, bclk toggles.
  - The wrap that drives bclk 1->0 is the "fall strobe"; lrclk and sdata update only on that same clk edge.
  - The sink samples on the bclk rising edge.
- Frame: bit index k in 0..63, advances on each fall strobe, wraps 63->0.
  - audio_lrclk = (k >= 32).
  - Frame word F = {L, zeros(SLOT_W-DATA_W), R, zeros(SLOT_W-DATA_W)}, 64 bits.
  - audio_sdata at index k = F[63-((k-1) mod 64)]. This is standard I2S 1-bit delay: left MSB appears at k=1, one bclk after lrclk falls; bit at k=0 is the last pad bit of the previous frame, i.e. 0.
- Load: at the fall strobe where k becomes 0, the frame shift register loads from the holding register.
  - If the holding register is full, it loads that pair and the holding register empties.
  - If empty, it loads zeros and underrun pulses high for exactly that clk.
- Handshake:
  - 1-entry holding register; in_ready = !hold_full.
  - Acceptance in the same clk as a load: the accepted pair stays in the holding register for the next frame. The current frame has already resolved as underrun.
  - The holding register cannot be written while full.
  - in_valid may be held high indefinitely; at most one transfer per frame drains.
- Reset (any cycle, including mid-frame): on the next clk edge
  - audio_bclk=0, audio_lrclk=0, audio_sdata=0, underrun=0, in_ready=0
  - div_cnt=0, k=63, hold empty, shift register zero
- After reset: in_ready=1 the first clk after rst deasserts. The first fall strobe after release starts a frame at k=0.
- Latency: a pair accepted while the holding register is empty reaches sdata (left MSB) at the next k=1, i.e. up to 65 bclk.

Optional Feature:
- I2S_TX_REPEAT_EN
  - Defined: on underrun the frame register reloads the last transmitted pair (zeros if none since reset). underrun still pulses.
  - Undefined: on underrun the block transmits a zero frame.

Decomposition:
- Package i2s_pkg holds:
  - FRAME_BITS=64 and SLOT_W default
  - Frame bit-index type (6-bit)
  - Helper constant for the pad width (SLOT_W-DATA_W)
- Sub-module i2s_bclk_gen: divider producing audio_bclk plus one-clk fall/rise strobes. It is reused by a future I2S master receiver.

Test Plan:
1. Reset release, CLK_DIV=2, no input -> bclk period 4 clk; lrclk toggles every 32 bclk; sdata=0 throughout; underrun pulses once per 64 bclk.
2. Push L=16'hA5C3, R=16'h0F01 -> with bits sampled on bclk rise, slot word left = 32'hA5C3_0000 starting 1 bclk after lrclk falls, right = 32'h0F01_0000 starting 1 bclk after lrclk rises. No underrun for that frame.
3. Loopback into i2s_rx; stream 8 pairs (L=n, R=~n) back-to-back -> receiver reports identical pairs in order, none dropped, zero underrun pulses.
4. Backpressure: hold in_valid=1 with two distinct pairs -> first accepted at once; in_ready stays low until the k=0 load; second accepted the clk after.
5. Underrun then arrival: skip one frame -> zero frame plus one underrun pulse; with I2S_TX_REPEAT_EN, the previous pair is repeated instead.
6. Assert rst at k=40 for 1 clk -> all outputs 0 the next edge; first new frame begins at k=0 after release, with the left MSB at k=1.
